// File: rtl/brick_map_pkg.sv
// Brick geometry defaults, health encodings and map FSM states shared by the
// ball, draw and brick map blocks.
package brick_map_pkg;

    localparam int DEF_COLS        = 20;
    localparam int DEF_ROWS        = 6;
    localparam int DEF_BRICKX_LOG2 = 5;
    localparam int DEF_BRICKY_LOG2 = 4;
    localparam int DEF_GRID_Y0     = 32;

    localparam logic [1:0] H_NONE = 2'd0;
    localparam logic [1:0] H_WEAK = 2'd1;
    localparam logic [1:0] H_MID  = 2'd2;
    localparam logic [1:0] H_FULL = 2'd3;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_HIT2 = 2'd2
    } map_state_t;

    // Top two rows are toughest, the next two medium, everything below is weak.
    function automatic logic [1:0] init_health(input logic [9:0] row);
        if (row < 10'd2)
            return H_FULL;
        else if (row < 10'd4)
            return H_MID;
        else
            return H_WEAK;
    endfunction

endpackage

// File: rtl/brick_map_addr.sv
// Pixel coordinate to brick cell lookup: linear cell index, in-grid flag and
// the brick origin (origin forced to 0 when the pixel is off the grid).
module brick_map_addr
    import brick_map_pkg::*;
#(
    parameter int COLS        = DEF_COLS,
    parameter int ROWS        = DEF_ROWS,
    parameter int BRICKX_LOG2 = DEF_BRICKX_LOG2,
    parameter int BRICKY_LOG2 = DEF_BRICKY_LOG2,
    parameter int GRID_Y0     = DEF_GRID_Y0,
    parameter int IW          = 7
) (
    input  logic [9:0]    px,
    input  logic [9:0]    py,
    output logic [IW-1:0] idx,
    output logic          in_grid,
    output logic [9:0]    org_x,
    output logic [9:0]    org_y
);

    logic [9:0] col;
    logic [9:0] row;
    logic [9:0] dy;
    logic [9:0] lin;

    assign col = px >> BRICKX_LOG2;
    // dy wraps when py is above the grid; the py compare below masks that case.
    assign dy  = py - 10'(GRID_Y0);
    assign row = dy >> BRICKY_LOG2;

    assign in_grid = (py >= 10'(GRID_Y0)) && (col < 10'(COLS)) && (row < 10'(ROWS));
    assign lin     = row * 10'(COLS) + col;
    assign idx     = IW'(lin);

    assign org_x = in_grid ? (col << BRICKX_LOG2) : '0;
    assign org_y = in_grid ? (10'(GRID_Y0) + (row << BRICKY_LOG2)) : '0;

endmodule

// File: rtl/brick_map.sv
// Brick health store: answers pixel probes with the containing brick and its
// health, applies up to two hit reports per cycle and announces each change.
//
// state  | meaning
// S_INIT | sweeping one cell per cycle with its starting health
// S_IDLE | map valid; hits applied on the edge they arrive
// S_HIT2 | applying the second of two simultaneous hits; new hits dropped
module brick_map
    import brick_map_pkg::*;
#(
    parameter int COLS        = DEF_COLS,
    parameter int ROWS        = DEF_ROWS,
    parameter int BRICKX_LOG2 = DEF_BRICKX_LOG2,
    parameter int BRICKY_LOG2 = DEF_BRICKY_LOG2,
    parameter int GRID_Y0     = DEF_GRID_Y0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       level_load,
    input  logic [9:0] memx,
    input  logic [9:0] memy,
    output logic [9:0] brickx,
    output logic [9:0] bricky,
    output logic [1:0] health,
    input  logic       hit_1,
    input  logic [9:0] hit_x1,
    input  logic [9:0] hit_y1,
    input  logic       hit_2,
    input  logic [9:0] hit_x2,
    input  logic [9:0] hit_y2,
    output logic       ready,
    output logic       chg_valid,
    output logic [9:0] chg_x,
    output logic [9:0] chg_y,
    output logic [1:0] chg_health,
    output logic [6:0] bricks_left,
    output logic       cleared
);

    localparam int NCELL = COLS * ROWS;
    localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCELL - 1);

    map_state_t    state, state_nxt;
    logic [1:0]    cells [NCELL];
    logic [IW-1:0] sweep_idx;
    logic [9:0]    sweep_col, sweep_row;

    logic [IW-1:0] p_idx, h1_idx, h2_idx, pend_idx, wr_idx;
    logic          p_in, h1_in, h2_in, pend_in, same_cell;
    logic [9:0]    p_ox, p_oy, h1_ox, h1_oy, h2_ox, h2_oy, pend_x, pend_y;
    logic [1:0]    p_cur, h1_cur, h2_cur, pend_cur, dec_cur, wr_val;
    logic          wr_en, dec_en, pend_load;
    logic [9:0]    dec_x, dec_y;

    brick_map_addr #(.COLS(COLS), .ROWS(ROWS), .BRICKX_LOG2(BRICKX_LOG2),
        .BRICKY_LOG2(BRICKY_LOG2), .GRID_Y0(GRID_Y0), .IW(IW)) u_addr_probe (
        .px(memx), .py(memy), .idx(p_idx), .in_grid(p_in), .org_x(p_ox), .org_y(p_oy));

    brick_map_addr #(.COLS(COLS), .ROWS(ROWS), .BRICKX_LOG2(BRICKX_LOG2),
        .BRICKY_LOG2(BRICKY_LOG2), .GRID_Y0(GRID_Y0), .IW(IW)) u_addr_hit1 (
        .px(hit_x1), .py(hit_y1), .idx(h1_idx), .in_grid(h1_in), .org_x(h1_ox), .org_y(h1_oy));

    brick_map_addr #(.COLS(COLS), .ROWS(ROWS), .BRICKX_LOG2(BRICKX_LOG2),
        .BRICKY_LOG2(BRICKY_LOG2), .GRID_Y0(GRID_Y0), .IW(IW)) u_addr_hit2 (
        .px(hit_x2), .py(hit_y2), .idx(h2_idx), .in_grid(h2_in), .org_x(h2_ox), .org_y(h2_oy));

    assign p_cur     = cells[p_idx];
    assign h1_cur    = cells[h1_idx];
    assign h2_cur    = cells[h2_idx];
    assign pend_cur  = cells[pend_idx];
    assign same_cell = h1_in && h2_in && (h1_idx == h2_idx);
    assign ready     = (state != S_INIT);

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_idx    = sweep_idx;
        wr_val    = init_health(sweep_row);
        dec_en    = 1'b0;
        dec_cur   = H_NONE;
        dec_x     = '0;
        dec_y     = '0;
        pend_load = 1'b0;
        unique case (state)
            S_INIT: begin
                wr_en = 1'b1;
                if (sweep_idx == LAST_IDX) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (hit_1 && hit_2 && !same_cell) begin
                    pend_load = 1'b1;
                    state_nxt = S_HIT2;
                end
                if (hit_1) begin
                    dec_en  = h1_in && (h1_cur != H_NONE);
                    wr_idx  = h1_idx;
                    dec_cur = h1_cur;
                    dec_x   = h1_ox;
                    dec_y   = h1_oy;
                end else if (hit_2) begin
                    dec_en  = h2_in && (h2_cur != H_NONE);
                    wr_idx  = h2_idx;
                    dec_cur = h2_cur;
                    dec_x   = h2_ox;
                    dec_y   = h2_oy;
                end
            end
            S_HIT2: begin
                state_nxt = S_IDLE;
                dec_en    = pend_in && (pend_cur != H_NONE);
                wr_idx    = pend_idx;
                dec_cur   = pend_cur;
                dec_x     = pend_x;
                dec_y     = pend_y;
            end
            default: state_nxt = S_INIT;
        endcase
        if (level_load) begin
            state_nxt = S_INIT;
            wr_en     = 1'b0;
            dec_en    = 1'b0;
            pend_load = 1'b0;
        end
        if (dec_en) begin
            wr_en  = 1'b1;
            wr_val = dec_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NCELL; i++) cells[i] <= H_NONE;
        end else if (wr_en) begin
            cells[wr_idx] <= wr_val;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_INIT;
            sweep_idx   <= '0;
            sweep_col   <= '0;
            sweep_row   <= '0;
            pend_idx    <= '0;
            pend_in     <= 1'b0;
            pend_x      <= '0;
            pend_y      <= '0;
            brickx      <= '0;
            bricky      <= '0;
            health      <= H_NONE;
            chg_valid   <= 1'b0;
            chg_x       <= '0;
            chg_y       <= '0;
            chg_health  <= H_NONE;
            bricks_left <= '0;
            cleared     <= 1'b0;
        end else begin
            state     <= state_nxt;
            brickx    <= p_ox;
            bricky    <= p_oy;
            health    <= (ready && p_in) ? p_cur : H_NONE;
            chg_valid <= dec_en;
            cleared   <= dec_en && (wr_val == H_NONE) && (bricks_left == 7'd1);
            if (dec_en) begin
                chg_x      <= dec_x;
                chg_y      <= dec_y;
                chg_health <= wr_val;
            end
            if (pend_load) begin
                pend_idx <= h2_idx;
                pend_in  <= h2_in;
                pend_x   <= h2_ox;
                pend_y   <= h2_oy;
            end
            if (level_load) begin
                sweep_idx   <= '0;
                sweep_col   <= '0;
                sweep_row   <= '0;
                bricks_left <= '0;
            end else if (state == S_INIT) begin
                sweep_idx   <= sweep_idx + 1'b1;
                bricks_left <= bricks_left + 7'd1;
                if (sweep_col == 10'(COLS - 1)) begin
                    sweep_col <= '0;
                    sweep_row <= sweep_row + 10'd1;
                end else begin
                    sweep_col <= sweep_col + 10'd1;
                end
            end else if (dec_en && (wr_val == H_NONE)) begin
                bricks_left <= bricks_left - 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_brick_map.sv
// Self-checking bench for brick_map: directed scenarios plus random probes,
// hits and reloads compared against a cell-array model of the playfield.
module tb_brick_map;

    localparam int COLS = 20;
    localparam int ROWS = 6;
    localparam int N    = COLS * ROWS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, level_load, hit_1, hit_2;
    logic [9:0] memx, memy, hit_x1, hit_y1, hit_x2, hit_y2;
    logic [9:0] brickx, bricky, chg_x, chg_y;
    logic [1:0] health, chg_health;
    logic       ready, chg_valid, cleared;
    logic [6:0] bricks_left;

    logic       s_level_load, s_hit_1, s_hit_2;
    logic [9:0] s_memx, s_memy, s_hit_x1, s_hit_y1, s_hit_x2, s_hit_y2;
    logic [9:0] s_brickx, s_bricky, s_chg_x, s_chg_y;
    logic [1:0] s_health, s_chg_health;
    logic       s_ready, s_chg_valid, s_cleared;
    logic [6:0] s_left;

    brick_map dut (
        .clk(clk), .resetn(resetn), .level_load(level_load),
        .memx(memx), .memy(memy), .brickx(brickx), .bricky(bricky), .health(health),
        .hit_1(hit_1), .hit_x1(hit_x1), .hit_y1(hit_y1),
        .hit_2(hit_2), .hit_x2(hit_x2), .hit_y2(hit_y2),
        .ready(ready), .chg_valid(chg_valid), .chg_x(chg_x), .chg_y(chg_y),
        .chg_health(chg_health), .bricks_left(bricks_left), .cleared(cleared));

    brick_map #(.COLS(2), .ROWS(1)) u_small (
        .clk(clk), .resetn(resetn), .level_load(s_level_load),
        .memx(s_memx), .memy(s_memy), .brickx(s_brickx), .bricky(s_bricky), .health(s_health),
        .hit_1(s_hit_1), .hit_x1(s_hit_x1), .hit_y1(s_hit_y1),
        .hit_2(s_hit_2), .hit_x2(s_hit_x2), .hit_y2(s_hit_y2),
        .ready(s_ready), .chg_valid(s_chg_valid), .chg_x(s_chg_x), .chg_y(s_chg_y),
        .chg_health(s_chg_health), .bricks_left(s_left), .cleared(s_cleared));

    int n_checks = 0;
    int n_pass   = 0;
    int n_clr    = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Playfield model: health per brick, sweep progress, and one queued hit.
    int mh [ROWS][COLS];
    bit m_ready;
    int m_sweep, m_left;
    bit m_pend;
    int m_px, m_py;
    int e_bx, e_by, e_h, e_cx, e_cy, e_ch;
    bit e_chg, e_clr;

    function automatic bit locate(input int x, input int y, output int c, output int r);
        c = x / 32;
        r = (y - 32) / 16;
        return (y >= 32) && (c < COLS) && (r < ROWS);
    endfunction

    task automatic model_hit(input int x, input int y);
        int c, r;
        if (locate(x, y, c, r) && mh[r][c] > 0) begin
            mh[r][c]--;
            e_chg = 1'b1;
            e_cx  = c * 32;
            e_cy  = 32 + r * 16;
            e_ch  = mh[r][c];
            if (mh[r][c] == 0) begin
                m_left--;
                if (m_left == 0) e_clr = 1'b1;
            end
        end
    endtask

    task automatic model_step();
        int c, r, c2, r2;
        bit in1, in2;
        e_chg = 1'b0;
        e_clr = 1'b0;
        if (locate(int'(memx), int'(memy), c, r)) begin
            e_bx = c * 32;
            e_by = 32 + r * 16;
            e_h  = m_ready ? mh[r][c] : 0;
        end else begin
            e_bx = 0; e_by = 0; e_h = 0;
        end
        if (level_load) begin
            m_ready = 1'b0; m_sweep = 0; m_left = 0; m_pend = 1'b0;
        end else if (!m_ready) begin
            r = m_sweep / COLS;
            c = m_sweep % COLS;
            mh[r][c] = (r < 2) ? 3 : (r < 4) ? 2 : 1;
            m_left++;
            m_sweep++;
            if (m_sweep == N) m_ready = 1'b1;
        end else if (m_pend) begin
            m_pend = 1'b0;
            model_hit(m_px, m_py);
        end else begin
            in1 = locate(int'(hit_x1), int'(hit_y1), c, r);
            in2 = locate(int'(hit_x2), int'(hit_y2), c2, r2);
            if (hit_1 && hit_2 && !(in1 && in2 && c == c2 && r == r2)) begin
                m_pend = 1'b1;
                m_px = int'(hit_x2);
                m_py = int'(hit_y2);
            end
            if (hit_1) model_hit(int'(hit_x1), int'(hit_y1));
            else if (hit_2) model_hit(int'(hit_x2), int'(hit_y2));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("ready", ready, m_ready);
        chk("bricks_left", bricks_left, m_left);
        chk("brickx", brickx, e_bx);
        chk("bricky", bricky, e_by);
        chk("health", health, e_h);
        chk("chg_valid", chg_valid, e_chg);
        chk("cleared", cleared, e_clr);
        if (e_chg) begin
            chk("chg_x", chg_x, e_cx);
            chk("chg_y", chg_y, e_cy);
            chk("chg_health", chg_health, e_ch);
        end
        if (cleared) n_clr++;
        level_load = 1'b0;
        hit_1 = 1'b0;
        hit_2 = 1'b0;
    endtask

    task automatic probe(input int x, input int y);
        memx = 10'(x);
        memy = 10'(y);
        tick();
    endtask

    task automatic rand_origin(output logic [9:0] x, output logic [9:0] y);
        if ($urandom_range(0, 9) == 0) begin
            x = 10'($urandom_range(0, 1023));
            y = 10'($urandom_range(0, 1023));
        end else begin
            x = 10'($urandom_range(0, COLS - 1) * 32);
            y = 10'(32 + $urandom_range(0, ROWS - 1) * 16);
        end
    endtask

    task automatic sweep_wait();
        repeat (N) begin
            memx = 10'($urandom_range(0, 700));
            memy = 10'($urandom_range(0, 160));
            tick();
        end
    endtask

    initial begin
        resetn = 1'b0; level_load = 1'b0; hit_1 = 1'b0; hit_2 = 1'b0;
        memx = '0; memy = '0; hit_x1 = '0; hit_y1 = '0; hit_x2 = '0; hit_y2 = '0;
        s_level_load = 1'b0; s_hit_1 = 1'b0; s_hit_2 = 1'b0;
        s_memx = '0; s_memy = '0; s_hit_x1 = '0; s_hit_y1 = '0; s_hit_x2 = '0; s_hit_y2 = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mh[r][c] = 0;
        m_ready = 1'b0; m_sweep = 0; m_left = 0; m_pend = 1'b0; m_px = 0; m_py = 0;

        #23;
        chk("rst_ready", ready, 0);
        chk("rst_left", bricks_left, 0);
        chk("rst_health", health, 0);
        chk("rst_brickx", brickx, 0);
        chk("rst_chg_valid", chg_valid, 0);
        chk("rst_cleared", cleared, 0);
        @(negedge clk);
        resetn = 1'b1;

        sweep_wait();
        chk("init_ready", ready, 1);
        chk("init_left", bricks_left, 120);

        probe(40, 33);
        chk("p1_bx", brickx, 32); chk("p1_by", bricky, 32); chk("p1_h", health, 3);
        probe(100, 120);
        chk("p2_bx", brickx, 96); chk("p2_by", bricky, 112); chk("p2_h", health, 1);
        probe(5, 10);
        chk("p3_bx", brickx, 0); chk("p3_by", bricky, 0); chk("p3_h", health, 0);

        for (int k = 0; k < 4; k++) begin
            hit_1 = 1'b1; hit_x1 = 10'd32; hit_y1 = 10'd32;
            tick();
            chk("rep_chg", chg_valid, (k < 3) ? 1 : 0);
            if (k < 3) chk("rep_health", chg_health, 2 - k);
            tick();
        end
        chk("rep_left", bricks_left, 119);

        hit_1 = 1'b1; hit_x1 = 10'd0;  hit_y1 = 10'd32;
        hit_2 = 1'b1; hit_x2 = 10'd64; hit_y2 = 10'd48;
        tick();
        chk("dual1_x", chg_x, 0); chk("dual1_v", chg_valid, 1);
        tick();
        chk("dual2_v", chg_valid, 1); chk("dual2_x", chg_x, 64); chk("dual2_h", chg_health, 2);
        hit_1 = 1'b1; hit_x1 = 10'd64; hit_y1 = 10'd48;
        hit_2 = 1'b1; hit_x2 = 10'd64; hit_y2 = 10'd48;
        tick();
        chk("same_h", chg_health, 1);
        tick();
        chk("same_once", chg_valid, 0);

        memx = 10'd70; memy = 10'd50;
        hit_1 = 1'b1; hit_x1 = 10'd64; hit_y1 = 10'd48;
        tick();
        chk("rbw_probe", health, 1); chk("rbw_chg", chg_health, 0);

        hit_1 = 1'b1; hit_x1 = 10'd0;  hit_y1 = 10'd48;
        hit_2 = 1'b1; hit_x2 = 10'd32; hit_y2 = 10'd48;
        tick();
        level_load = 1'b1;
        tick();
        chk("ll_pend_lost", chg_valid, 0);
        chk("ll_ready", ready, 0);
        sweep_wait();
        probe(64, 48);
        chk("ll_restore", health, 3);

        repeat (2500) begin
            memx = 10'($urandom_range(0, 700));
            memy = 10'($urandom_range(0, 160));
            hit_1 = ($urandom_range(0, 3) == 0);
            hit_2 = ($urandom_range(0, 3) == 0);
            rand_origin(hit_x1, hit_y1);
            if ($urandom_range(0, 3) == 0) begin
                hit_x2 = hit_x1; hit_y2 = hit_y1;
            end else begin
                rand_origin(hit_x2, hit_y2);
            end
            level_load = ($urandom_range(0, 499) == 0);
            tick();
        end

        level_load = 1'b1;
        tick();
        sweep_wait();
        n_clr = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                while (mh[r][c] > 0) begin
                    hit_1 = 1'b1; hit_x1 = 10'(c * 32); hit_y1 = 10'(32 + r * 16);
                    tick();
                    tick();
                end
        chk("clear_left", bricks_left, 0);
        chk("clear_once", n_clr, 1);

        chk("s_ready", s_ready, 1);
        chk("s_left_init", s_left, 2);
        for (int k = 0; k < 6; k++) begin
            s_hit_1 = 1'b1; s_hit_x1 = (k < 3) ? 10'd0 : 10'd32; s_hit_y1 = 10'd32;
            tick();
            chk("s_chg", s_chg_valid, 1);
            chk("s_health", s_chg_health, 2 - (k % 3));
            chk("s_left", s_left, (k < 2) ? 2 : (k < 5) ? 1 : 0);
            chk("s_cleared", s_cleared, (k == 5) ? 1 : 0);
            s_hit_1 = 1'b0;
            tick();
            chk("s_cleared_pulse", s_cleared, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
